// File: rtl/mod16_seq_ctrl.sv
// mod16_seq_ctrl: command-driven sequencer around a mod-2^WIDTH up-counter
module mod16_seq_ctrl #(
    parameter int WIDTH      = 4,
    parameter int DEFAULT_TC = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_tc,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             paused,
    output logic             done,
    output logic             wrap
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
    localparam logic [1:0] OP_STOP = 2'b10;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d, tc_q, tc_d;
    logic             cont_q, cont_d, wrap_q, wrap_d, acc;
    // next state and datapath; a START from any accepting state restarts the run and drops any pending wrap
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        tc_d    = tc_q;
        cont_d  = cont_q;
        wrap_d  = 1'b0;
        acc     = cmd_valid && (state_q != DONE);
        if (acc && !cmd_op[1]) begin
            state_d = RUN;
            q_d     = '0;
            tc_d    = cmd_tc;
            cont_d  = cmd_op[0];
        end else begin
            case (state_q)
                RUN: begin
                    if (acc) begin
                        state_d = (cmd_op == OP_STOP) ? IDLE : PAUSE;
                        q_d     = (cmd_op == OP_STOP) ? '0 : q_q;
                    end else if (q_q < tc_q) begin
                        q_d = q_q + 1'b1;
                    end else if (cont_q) begin
                        q_d    = '0;
                        wrap_d = 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end
                PAUSE: begin
                    if (acc) begin
                        state_d = (cmd_op == OP_STOP) ? IDLE : RUN;
                        q_d     = (cmd_op == OP_STOP) ? '0 : q_q;
                    end
                end
                DONE: state_d = IDLE;
                default: ;
            endcase
        end
    end
    // state and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            q_q     <= '0;
            tc_q    <= WIDTH'(DEFAULT_TC);
            cont_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            tc_q    <= tc_d;
            cont_q  <= cont_d;
            wrap_q  <= wrap_d;
        end
    end
    assign q         = q_q;
    assign busy      = (state_q == RUN) || (state_q == PAUSE);
    assign paused    = (state_q == PAUSE);
    assign done      = (state_q == DONE);
    assign wrap      = wrap_q;
    assign cmd_ready = (state_q != DONE);
endmodule

// File: tb/tb_mod16_seq_ctrl.sv
// tb_mod16_seq_ctrl: randomized and directed checks against an arithmetic run model
module tb_mod16_seq_ctrl;
    localparam int WIDTH = 4;
    localparam int DEFAULT_TC = 15;
    logic clk, rst, cmd_valid, cmd_ready, busy, paused, done, wrap;
    logic [1:0] cmd_op;
    logic [WIDTH-1:0] cmd_tc, q;
    logic [WIDTH+4:0] obs;
    int total, bad;
    int m_tc, m_k;
    bit m_active, m_paused, m_done, m_wrap, m_cont;
    logic [WIDTH-1:0] m_qidle;

    mod16_seq_ctrl #(.WIDTH(WIDTH), .DEFAULT_TC(DEFAULT_TC)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_tc(cmd_tc), .q(q), .busy(busy), .paused(paused),
        .done(done), .wrap(wrap)
    );

    assign obs = {q, busy, paused, done, wrap, cmd_ready};

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic void model_reset();
        m_tc = DEFAULT_TC; m_k = 0; m_active = 0; m_paused = 0;
        m_done = 0; m_wrap = 0; m_cont = 0; m_qidle = '0;
    endfunction

    // q is the tick count k: clamped at tc for one-shot, k mod (tc+1) for continuous
    function automatic logic [WIDTH+4:0] exp_vec();
        logic [WIDTH-1:0] eq;
        eq = m_active ? (m_cont ? WIDTH'(m_k % (m_tc + 1)) : WIDTH'(m_k))
                      : (m_done ? WIDTH'(m_tc) : m_qidle);
        return {eq, m_active, m_active && m_paused, m_done, m_wrap, !m_done};
    endfunction

    task automatic drive(input logic v, input logic [1:0] op, input logic [WIDTH-1:0] tc);
        bit acc;
        cmd_valid = v; cmd_op = op; cmd_tc = tc;
        acc = v && !m_done;
        @(posedge clk);
        m_wrap = 0;
        if (m_done) begin
            m_done = 0;
            m_qidle = WIDTH'(m_tc);
        end else if (acc && !op[1]) begin
            m_tc = int'(tc); m_cont = op[0]; m_active = 1; m_paused = 0; m_k = 0;
        end else if (acc && op == 2'b10) begin
            if (m_active) m_qidle = '0;
            m_active = 0;
        end else if (acc && op == 2'b11) begin
            if (m_active) m_paused = !m_paused;
        end else if (m_active && !m_paused) begin
            if (!m_cont && m_k == m_tc) begin
                m_done = 1; m_active = 0;
            end else begin
                m_k++;
                m_wrap = m_cont && (m_k % (m_tc + 1) == 0);
            end
        end
        #1;
        cmd_valid = 0;
    endtask

    task automatic test_reset();
        rst = 0; cmd_valid = 0; cmd_op = 0; cmd_tc = 0;
        model_reset();
        @(posedge clk); #1;
        total++;
        if (obs !== 9'b0000_0000_1) begin bad++; $display("FAIL reset_state: got %b want %b", obs, 9'b000000001); end
        rst = 1;
        drive(1, 2'b10, 4'd3);
        total++;
        if (obs !== exp_vec()) begin bad++; $display("FAIL idle_stop: got %b want %b", obs, exp_vec()); end
    endtask

    task automatic test_oneshot();
        int done_at, done_cnt;
        logic [WIDTH-1:0] done_q;
        logic done_rdy;
        done_at = -1; done_cnt = 0; done_q = 'x; done_rdy = 1'bx;
        drive(1, 2'b00, 4'd5);
        total++;
        if (obs !== exp_vec() || q !== 0) begin bad++; $display("FAIL oneshot_start: got %b want %b", obs, exp_vec()); end
        for (int j = 1; j <= 8; j++) begin
            drive(0, 2'b00, 4'd0);
            total++;
            if (obs !== exp_vec()) begin bad++; $display("FAIL oneshot_cycle%0d: got %b want %b", j, obs, exp_vec()); end
            if (done) begin done_cnt++; done_at = j; done_q = q; done_rdy = cmd_ready; end
        end
        total++;
        if (done_cnt !== 1 || done_at !== 6) begin bad++; $display("FAIL oneshot_done_timing: got cnt=%0d at=%0d want cnt=1 at=6", done_cnt, done_at); end
        total++;
        if (done_q !== 5 || done_rdy !== 0) begin bad++; $display("FAIL oneshot_done_state: got q=%0d rdy=%b want q=5 rdy=0", done_q, done_rdy); end
        total++;
        if (busy !== 0 || q !== 5) begin bad++; $display("FAIL oneshot_idle: got busy=%b q=%0d want busy=0 q=5", busy, q); end
    endtask

    task automatic test_cont();
        int wraps[$];
        int dones;
        dones = 0;
        drive(1, 2'b01, 4'd15);
        for (int j = 1; j <= 40; j++) begin
            drive(0, 2'b00, 4'd0);
            total++;
            if (obs !== exp_vec()) begin bad++; $display("FAIL cont_cycle%0d: got %b want %b", j, obs, exp_vec()); end
            if (wrap) wraps.push_back(j);
            if (done) dones++;
        end
        total++;
        if (wraps.size() != 2 || dones != 0) begin bad++; $display("FAIL cont_pulses: got wraps=%0d dones=%0d want wraps=2 dones=0", wraps.size(), dones); end
        else begin
            total++;
            if (wraps[0] != 16 || wraps[1] - wraps[0] != 16) begin bad++; $display("FAIL cont_wrap_spacing: got %0d,%0d want 16,32", wraps[0], wraps[1]); end
        end
        drive(1, 2'b10, 4'd0);
    endtask

    task automatic test_pause();
        drive(1, 2'b01, 4'd3);
        for (int i = 0; i < 10 && q !== 2; i++) drive(0, 2'b00, 4'd0);
        total++;
        if (q !== 2) begin bad++; $display("FAIL pause_reach: got q=%0d want 2", q); end
        drive(1, 2'b11, 4'd9);
        for (int j = 0; j < 4; j++) begin
            total++;
            if (q !== 2 || paused !== 1 || busy !== 1 || obs !== exp_vec()) begin bad++; $display("FAIL pause_hold%0d: got %b want q=2 paused", j, obs); end
            drive(0, 2'b00, 4'd0);
        end
        drive(1, 2'b11, 4'd0);
        total++;
        if (q !== 2 || paused !== 0 || obs !== exp_vec()) begin bad++; $display("FAIL pause_resume: got %b want %b", obs, exp_vec()); end
        drive(0, 2'b00, 4'd0);
        total++;
        if (q !== 3 || wrap !== 0) begin bad++; $display("FAIL pause_next: got q=%0d wrap=%b want q=3 wrap=0", q, wrap); end
        drive(0, 2'b00, 4'd0);
        total++;
        if (q !== 0 || wrap !== 1 || obs !== exp_vec()) begin bad++; $display("FAIL pause_wrap: got q=%0d wrap=%b want q=0 wrap=1", q, wrap); end
        drive(1, 2'b10, 4'd0);
    endtask

    task automatic test_stop_restart();
        drive(1, 2'b00, 4'd9);
        for (int i = 0; i < 12 && q !== 4; i++) drive(0, 2'b00, 4'd0);
        total++;
        if (q !== 4) begin bad++; $display("FAIL stop_reach: got q=%0d want 4", q); end
        drive(1, 2'b10, 4'd7);
        total++;
        if (q !== 0 || busy !== 0 || done !== 0 || obs !== exp_vec()) begin bad++; $display("FAIL stop_idle: got %b want %b", obs, exp_vec()); end
        for (int j = 0; j < 3; j++) begin
            drive(0, 2'b00, 4'd0);
            total++;
            if (done !== 0 || q !== 0) begin bad++; $display("FAIL stop_nodone%0d: got done=%b q=%0d want done=0 q=0", j, done, q); end
        end
        drive(1, 2'b00, 4'd9);
        for (int i = 0; i < 12 && q !== 6; i++) drive(0, 2'b00, 4'd0);
        total++;
        if (q !== 6) begin bad++; $display("FAIL restart_reach: got q=%0d want 6", q); end
        drive(1, 2'b01, 4'd2);
        total++;
        if (q !== 0 || busy !== 1 || obs !== exp_vec()) begin bad++; $display("FAIL restart_zero: got %b want %b", obs, exp_vec()); end
        for (int j = 1; j <= 3; j++) begin
            drive(0, 2'b00, 4'd0);
            total++;
            if (obs !== exp_vec()) begin bad++; $display("FAIL restart_cycle%0d: got %b want %b", j, obs, exp_vec()); end
        end
        total++;
        if (q !== 0 || wrap !== 1) begin bad++; $display("FAIL restart_newtc: got q=%0d wrap=%b want q=0 wrap=1", q, wrap); end
        drive(1, 2'b10, 4'd0);
    endtask

    task automatic test_tc0();
        drive(1, 2'b00, 4'd0);
        total++;
        if (q !== 0 || busy !== 1 || done !== 0) begin bad++; $display("FAIL tc0_start: got %b", obs); end
        drive(0, 2'b00, 4'd0);
        total++;
        if (done !== 1 || q !== 0 || cmd_ready !== 0 || obs !== exp_vec()) begin bad++; $display("FAIL tc0_done: got %b want %b", obs, exp_vec()); end
        drive(0, 2'b00, 4'd0);
        total++;
        if (done !== 0 || busy !== 0 || cmd_ready !== 1) begin bad++; $display("FAIL tc0_idle: got %b", obs); end
        drive(1, 2'b01, 4'd0);
        for (int j = 0; j < 5; j++) begin
            drive(0, 2'b00, 4'd0);
            total++;
            if (q !== 0 || wrap !== 1 || done !== 0 || obs !== exp_vec()) begin bad++; $display("FAIL tc0_cont%0d: got %b want %b", j, obs, exp_vec()); end
        end
        drive(1, 2'b10, 4'd0);
    endtask

    task automatic test_async_reset();
        int done_at;
        done_at = -1;
        drive(1, 2'b00, 4'd12);
        for (int i = 0; i < 12 && q !== 7; i++) drive(0, 2'b00, 4'd0);
        total++;
        if (q !== 7) begin bad++; $display("FAIL areset_reach: got q=%0d want 7", q); end
        #2 rst = 0;
        #1;
        model_reset();
        total++;
        if (obs !== 9'b000000001) begin bad++; $display("FAIL areset_immediate: got %b want %b", obs, 9'b000000001); end
        #1 rst = 1;
        drive(1, 2'b00, 4'(DEFAULT_TC));
        for (int j = 1; j <= 18; j++) begin
            drive(0, 2'b00, 4'd0);
            total++;
            if (obs !== exp_vec()) begin bad++; $display("FAIL areset_run%0d: got %b want %b", j, obs, exp_vec()); end
            if (done && done_at < 0) done_at = j;
        end
        total++;
        if (done_at != DEFAULT_TC + 1) begin bad++; $display("FAIL areset_full_count: got done at %0d want %0d", done_at, DEFAULT_TC + 1); end
    endtask

    task automatic test_random();
        logic v;
        logic [1:0] op;
        logic [WIDTH-1:0] tc;
        for (int j = 0; j < 400; j++) begin
            v  = ($urandom_range(0, 3) == 0);
            op = 2'($urandom_range(0, 3));
            tc = WIDTH'($urandom_range(0, 15) < 12 ? $urandom_range(0, 5) : $urandom_range(0, 15));
            drive(v, op, tc);
            total++;
            if (obs !== exp_vec()) begin bad++; $display("FAIL random%0d: got %b want %b", j, obs, exp_vec()); end
            total++;
            if (done && wrap) begin bad++; $display("FAIL random_excl%0d: got done=1 wrap=1 want not both", j); end
        end
    endtask

    initial begin
        total = 0; bad = 0;
        test_reset();
        test_oneshot();
        test_cont();
        test_pause();
        test_stop_restart();
        test_tc0();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mod16_seq_ctrl.md
Name: mod16_seq_ctrl

Overview:
- Command-driven sequencer wrapped around a 4-bit mod-16 up-counter datapath.
- Accepts start/stop/pause commands over a valid/ready handshake.
- Supports a programmable terminal count (tc), one-shot or continuous mode, and emits done/wrap pulses.
- Sits between a host/control FSM and the counter. It is the only agent that loads, clears, enables or pauses the count.

Parameters:
- WIDTH, 4: counter width; count range 0..2^WIDTH-1.
- DEFAULT_TC, 15: terminal count loaded at reset. Must fit in WIDTH bits.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command this cycle.
- cmd_op  input  2  00 START_ONESHOT, 01 START_CONT, 10 STOP, 11 PAUSE_TOGGLE.
- cmd_tc  input  WIDTH  terminal count; sampled only on an accepted START_*.
- q  output  WIDTH  current count (registered).
- busy  output  1  high in RUN or PAUSE.
- paused  output  1  high in PAUSE.
- done  output  1  one-cycle pulse; one-shot run completed.
- wrap  output  1  one-cycle pulse; continuous run rolled over from tc to 0.

Behaviour:
- Reset (rst=0, async, independent of clk):
  - state=IDLE, q=0, tc_reg=DEFAULT_TC, mode=ONESHOT.
  - done=0, wrap=0, busy=0, paused=0, cmd_ready=1.
  - All outputs take these values immediately, including mid-run.
- Handshake:
  - A command is accepted on a rising edge where cmd_valid and cmd_ready are both 1.
  - cmd_ready=1 in IDLE, RUN and PAUSE; cmd_ready=0 in DONE.
  - At most one command is accepted per cycle.
- States: IDLE, RUN, PAUSE, DONE. All outputs are registered and derived from state; no combinational paths from inputs to outputs.
- IDLE:
  - START_*: latch tc_reg=cmd_tc and the mode; q<=0; go to RUN.
  - STOP or PAUSE_TOGGLE: accepted with no effect; q holds its value.
- RUN, no command:
  - q<tc_reg: q<=q+1.
  - q==tc_reg, ONESHOT: q holds tc_reg; go to DONE.
  - q==tc_reg, CONT: q<=0; wrap<=1 for one cycle; stay in RUN.
- RUN, with command:
  - STOP: q<=0; go to IDLE.
  - PAUSE_TOGGLE: q holds (no increment that cycle); go to PAUSE.
  - START_*: restart. Reload tc_reg and mode, q<=0, stay in RUN. Any pending wrap/done for that cycle is suppressed.
- PAUSE:
  - q frozen; busy=1, paused=1.
  - PAUSE_TOGGLE: go to RUN; increments resume on the following edge.
  - STOP: q<=0; go to IDLE.
  - START_*: restart as in RUN.
- DONE:
  - Lasts exactly one cycle; done=1, q=tc_reg, cmd_ready=0.
  - Unconditionally returns to IDLE.
  - q keeps tc_reg in IDLE until the next START or reset.
- Timing:
  - START accepted at edge t: q=0 after t, q=k after edge t+k.
  - ONESHOT: q=tc_reg after edge t+tc; done high in the cycle after edge t+tc+1; IDLE after edge t+tc+2.
  - CONT: period is tc_reg+1 cycles. wrap is high in the cycle where q has just returned to 0.
- Boundaries:
  - tc=0 ONESHOT: DONE one edge after RUN is entered.
  - tc=0 CONT: q stays 0 and wrap is high every cycle.
  - tc=2^WIDTH-1: full mod-16 sequence 0..15, no arithmetic overflow (compare happens before increment).
- cmd_tc is ignored for STOP and PAUSE_TOGGLE. cmd_op is don't-care when cmd_valid=0.
- done and wrap are never high simultaneously.

Test Plan:
- Reset then START_ONESHOT with tc=5 → q steps 0,1,2,3,4,5; done=1 for exactly one cycle with q=5; cmd_ready=0 in that cycle; then IDLE with busy=0 and q=5.
- START_CONT with tc=15 for 40 cycles → q runs 0..15, 0..15, …; wrap pulses at q=0 after each rollover, spaced 16 cycles apart; done never asserts.
- START_CONT with tc=3; PAUSE_TOGGLE at q=2; hold 4 cycles; PAUSE_TOGGLE → q frozen at 2 with paused=1 while paused; resumes with 3, then 0 plus a wrap pulse.
- START_ONESHOT with tc=9; STOP at q=4 → next cycle q=0, state IDLE, busy=0, no done pulse. A START_CONT issued at q=6 of a new run → q=0 next cycle with the new tc in effect.
- tc=0 edge cases → ONESHOT gives done on the second edge after START; CONT holds q=0 with wrap continuously high.
- Async reset: drive rst=0 between clock edges mid-RUN at q=7 → q=0, busy=0, cmd_ready=1 immediately, without waiting for clk. After rst=1, a START_ONESHOT with no prior tc programmed counts to DEFAULT_TC=15.
